run_sequencer: RTL and testbench
================================

// Module: run_sequencer
// PURPOSE
//   Upstream launch/monitor stage for the single-cycle CPU core. Pulses the core's req
//   input long enough to span the divided core clock, then watches the core's ack
//   (PC == done address) until it is stable. Reports completion, timeout and elapsed
//   cycle count to the host/testbench.
//   Sits between host control and the CPU top level, on the same undivided 'clock'.
// PARAMETERS
//   REQ_CYCLES      4       cycles req is held high per launch; >=1, >= clock-divide ratio
//   ACK_FILTER      2       consecutive high ack samples needed to accept completion; >=1
//   TIMEOUT_CYCLES  100000  run budget in cycles; must be < 2**COUNT_W
//   COUNT_W         20      width of cycle_count
// PORTS
//   clock        in   1        system clock (undivided; same net that feeds the CPU top)
//   reset        in   1        asynchronous, active-high reset
//   start        in   1        host launch request; sampled only in IDLE/DONE/TIMEOUT
//   abort        in   1        host cancel; effective in LAUNCH/RUN only
//   ack          in   1        core's ack output (combinational in core; registered here)
//   req          out  1        drives core's req/start input
//   busy         out  1        high in LAUNCH and RUN
//   done         out  1        sticky: program reached done address
//   timed_out    out  1        sticky: budget exhausted without qualified ack
//   cycle_count  out  COUNT_W  cycles spent in LAUNCH+RUN for the current/last run
// BEHAVIOUR
//   Clock and reset: one clock; reset is asynchronous and active-high.
//   All outputs are registered. Reset immediately forces: state=IDLE, req=0, busy=0,
//   done=0, timed_out=0, cycle_count=0, ack filter=0. This applies at any point,
//   including mid-run.
//   States: IDLE, LAUNCH, RUN, DONE, TIMEOUT (run_state_t).
//   IDLE/DONE/TIMEOUT + start=1 -> LAUNCH at next edge.
//     On that edge: cycle_count<=0, done<=0, timed_out<=0, req<=1, busy<=1.
//   LAUNCH: req=1 for exactly REQ_CYCLES cycles, then RUN with req<=0.
//     ack is ignored in LAUNCH; the filter is held at 0 because the core PC is resetting.
//   RUN: ack filter counts consecutive ack=1 cycles and clears on any ack=0.
//     When the filter reaches ACK_FILTER -> DONE: done<=1, busy<=0.
//   cycle_count: +1 on every edge while in LAUNCH or RUN. Saturates at 2**COUNT_W-1.
//     It is frozen in IDLE, DONE and TIMEOUT, and holds its last value until the next launch.
//   Timeout: in RUN, if cycle_count == TIMEOUT_CYCLES at the edge and ack does not
//     qualify -> TIMEOUT: timed_out<=1, busy<=0.
//   Simultaneous ack qualification and timeout on the same edge -> DONE wins.
//   abort=1 in LAUNCH/RUN -> IDLE: req<=0, busy<=0, done/timed_out stay 0, count frozen.
//   abort has priority over ack and timeout on the same edge. abort is ignored elsewhere.
//   start while busy: ignored, with no restart and no count reset.
//   start and abort together in IDLE/DONE/TIMEOUT: start wins, since abort is not applicable.
//   done and timed_out are never high together.
//   Latency: req rises 1 cycle after start is sampled. done rises ACK_FILTER cycles
//   after the first qualifying ack edge.
// STRUCTURE
//   definitions package: add typedef enum logic[2:0] run_state_t
//     {RS_IDLE, RS_LAUNCH, RS_RUN, RS_DONE, RS_TIMEOUT}.
//   Parameters stay module-local.
//   One sub-module: sat_counter #(W), a saturating up-counter with clr/en/q.
//     Instantiated for cycle_count; the LAUNCH hold counter and ack filter are inline.
//   Instantiated in the CPU top-level bench:
//     req -> CPU req; CPU ack -> ack; clock shared with the CPU top.
// TESTING (REQ_CYCLES=4, ACK_FILTER=2, TIMEOUT_CYCLES=50, COUNT_W=8 unless noted)
//   1 Normal run: start pulse edge 0; model raises ack at edge 20 and holds it
//     -> req high edges 1..4, busy 1..21, done=1 at edge 22, cycle_count=21, then frozen.
//   2 Ack glitch: ack high 1 cycle at edge 10, low, then high from edge 30
//     -> no done at 10-12; done at edge 32.
//   3 Timeout: ack never rises -> timed_out=1 on the edge after cycle_count hits 50,
//     done=0, req=0, count stays 50.
//   4 Tie: ack qualifies on the same edge cycle_count==50 -> done=1, timed_out=0.
//   5 Control: start re-pulsed during RUN -> ignored, count continues.
//     abort at edge 8 -> IDLE with req=0 and count=7.
//     Restart from DONE clears done and count.
//   6 Async reset mid-RUN: reset asserted between edges -> req/busy/done/count 0
//     before the next edge; after release, IDLE until start.

Source files
------------

// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding and a small state helper.
package run_sequencer_pkg;

  typedef enum logic [2:0] {
    RS_IDLE,
    RS_LAUNCH,
    RS_RUN,
    RS_DONE,
    RS_TIMEOUT
  } run_state_t;

  // LAUNCH and RUN are the states in which a run is in flight and time is charged to it.
  function automatic logic is_active(input run_state_t s);
    return (s == RS_LAUNCH) || (s == RS_RUN);
  endfunction

endpackage

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter: synchronous clear has priority over enable; holds at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  logic [W-1:0] count_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && (count_reg != MAX_VAL)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign q = count_reg;

endmodule

// File: rtl/run_sequencer.sv
// Launch/monitor stage for the CPU core: holds req across the divided core clock, then
// waits for a filtered ack, reporting done / timeout and the cycles spent on the run.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int REQ_CYCLES     = 4,
  parameter int ACK_FILTER     = 2,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int COUNT_W        = 20
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               ack,
  output logic               req,
  output logic               busy,
  output logic               done,
  output logic               timed_out,
  output logic [COUNT_W-1:0] cycle_count
);

  localparam int LAUNCH_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam int FILTER_W = (ACK_FILTER > 1) ? $clog2(ACK_FILTER) : 1;
  localparam logic [LAUNCH_W-1:0] LAUNCH_LAST = LAUNCH_W'(REQ_CYCLES - 1);
  localparam logic [FILTER_W-1:0] FILTER_LAST = FILTER_W'(ACK_FILTER - 1);
  localparam logic [COUNT_W-1:0]  TIMEOUT_VAL = COUNT_W'(TIMEOUT_CYCLES);

  run_state_t          state_reg, state_next;
  logic [LAUNCH_W-1:0] launch_cnt_reg, launch_cnt_next;
  logic [FILTER_W-1:0] filter_reg, filter_next;
  logic                ack_reg;
  logic                req_reg, req_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                timed_out_reg, timed_out_next;
  logic                count_clr, count_en;
  logic                ack_qualified;
  logic                budget_spent;
  logic [COUNT_W-1:0]  count_q;

  sat_counter #(
    .W(COUNT_W)
  ) u_cycle_count (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .en    (count_en),
    .q     (count_q)
  );

  // Qualification happens on the edge that would push the filter to ACK_FILTER.
  assign ack_qualified = ack_reg && (filter_reg == FILTER_LAST);
  assign budget_spent  = (count_q >= TIMEOUT_VAL);

  always_comb begin
    state_next      = state_reg;
    launch_cnt_next = launch_cnt_reg;
    filter_next     = '0;
    req_next        = req_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    timed_out_next  = timed_out_reg;
    count_clr       = 1'b0;
    count_en        = is_active(state_reg);

    case (state_reg)
      RS_IDLE, RS_DONE, RS_TIMEOUT: begin
        if (start) begin
          state_next      = RS_LAUNCH;
          launch_cnt_next = '0;
          count_clr       = 1'b1;
          done_next       = 1'b0;
          timed_out_next  = 1'b0;
          req_next        = 1'b1;
          busy_next       = 1'b1;
        end
      end

      RS_LAUNCH: begin
        if (abort) begin
          state_next = RS_IDLE;
          req_next   = 1'b0;
          busy_next  = 1'b0;
        end else if (launch_cnt_reg == LAUNCH_LAST) begin
          state_next = RS_RUN;
          req_next   = 1'b0;
        end else begin
          launch_cnt_next = launch_cnt_reg + LAUNCH_W'(1);
        end
      end

      RS_RUN: begin
        if (abort) begin
          state_next = RS_IDLE;
          req_next   = 1'b0;
          busy_next  = 1'b0;
        end else if (ack_qualified) begin
          state_next = RS_DONE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else if (budget_spent) begin
          // The count is left at the budget value so the host sees exactly what was spent.
          state_next     = RS_TIMEOUT;
          timed_out_next = 1'b1;
          busy_next      = 1'b0;
          count_en       = 1'b0;
        end else begin
          filter_next = ack_reg ? (filter_reg + FILTER_W'(1)) : '0;
        end
      end

      default: begin
        state_next = RS_IDLE;
        req_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= RS_IDLE;
      launch_cnt_reg <= '0;
      filter_reg     <= '0;
      ack_reg        <= 1'b0;
      req_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      timed_out_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      launch_cnt_reg <= launch_cnt_next;
      filter_reg     <= filter_next;
      ack_reg        <= ack;
      req_reg        <= req_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      timed_out_reg  <= timed_out_next;
    end
  end

  assign req         = req_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign timed_out   = timed_out_reg;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Scenario bench for run_sequencer: expected run outcomes are queued at launch and checked on completion.
module tb_run_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       ack   = 1'b0;
  logic       req, busy, done, timed_out;
  logic [7:0] cycle_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         end_edge;
    logic       done;
    logic       timed_out;
    logic       check_count;
    logic [7:0] count;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  run_sequencer #(
    .REQ_CYCLES    (4),
    .ACK_FILTER    (2),
    .TIMEOUT_CYCLES(50),
    .COUNT_W       (8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .ack        (ack),
    .req        (req),
    .busy       (busy),
    .done       (done),
    .timed_out  (timed_out),
    .cycle_count(cycle_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start is sampled on the next edge; that edge is called edge 1 of the run.
  task automatic launch();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // ack is high when sampled at edges a0..a1 and from b0 on. Returns the edge busy fell.
  task automatic run_until_idle(input int a0, input int a1, input int b0, input int budget,
                                output int end_edge, output int req_edges, output int busy_edges);
    int e;
    e          = 1;
    end_edge   = -1;
    req_edges  = req ? 1 : 0;
    busy_edges = busy ? 1 : 0;
    while (e < budget) begin
      ack = (((e + 1) >= a0) && ((e + 1) <= a1)) || ((e + 1) >= b0);
      step();
      e++;
      if (req)  req_edges++;
      if (busy) busy_edges++;
      if (!busy) begin
        end_edge = e;
        break;
      end
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++;
    if ({req, busy, done, timed_out, cycle_count} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0", {req, busy, done, timed_out, cycle_count});
    end
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    repeat (3) step();
    total++;
    if ({req, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL reset_idle got=%b want=000", {req, busy, done});
    end
    $display("reset: req=%0b busy=%0b count=%0d", req, busy, cycle_count);
  endtask

  task automatic test_normal();
    int end_e, req_e, busy_e;
    exp_t x;
    launch();
    total++;
    if ({req, busy, cycle_count} !== {1'b1, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL normal_launch got req=%0b busy=%0b count=%0d want 1 1 0", req, busy, cycle_count);
    end
    sb.push_back('{22, 1'b1, 1'b0, 1'b1, 8'd21});
    run_until_idle(1000, 0, 20, 100, end_e, req_e, busy_e);
    x = sb.pop_front();
    total++;
    if (end_e !== x.end_edge) begin bad++; $display("FAIL normal_end_edge got=%0d want=%0d", end_e, x.end_edge); end
    total++;
    if ({done, timed_out} !== {x.done, x.timed_out}) begin bad++; $display("FAIL normal_flags got=%b want=%b", {done, timed_out}, {x.done, x.timed_out}); end
    total++;
    if (cycle_count !== x.count) begin bad++; $display("FAIL normal_count got=%0d want=%0d", cycle_count, x.count); end
    total++;
    if (req_e != 4) begin bad++; $display("FAIL normal_req_cycles got=%0d want=4", req_e); end
    total++;
    if (busy_e != 21) begin bad++; $display("FAIL normal_busy_cycles got=%0d want=21", busy_e); end
    repeat (5) step();
    total++;
    if ({done, cycle_count} !== {1'b1, 8'd21}) begin
      bad++;
      $display("FAIL normal_frozen got done=%0b count=%0d want 1 21", done, cycle_count);
    end
    $display("normal: end=%0d done=%0b count=%0d", end_e, done, cycle_count);
  endtask

  task automatic test_ack_glitch();
    int end_e, req_e, busy_e;
    exp_t x;
    launch();
    sb.push_back('{32, 1'b1, 1'b0, 1'b1, 8'd31});
    run_until_idle(10, 10, 30, 100, end_e, req_e, busy_e);
    x = sb.pop_front();
    total++;
    if (end_e !== x.end_edge) begin bad++; $display("FAIL glitch_end_edge got=%0d want=%0d", end_e, x.end_edge); end
    total++;
    if ({done, timed_out} !== {x.done, x.timed_out}) begin bad++; $display("FAIL glitch_flags got=%b want=%b", {done, timed_out}, {x.done, x.timed_out}); end
    total++;
    if (cycle_count !== x.count) begin bad++; $display("FAIL glitch_count got=%0d want=%0d", cycle_count, x.count); end
    $display("ack_glitch: end=%0d done=%0b count=%0d", end_e, done, cycle_count);
  endtask

  task automatic test_timeout();
    int end_e, req_e, busy_e;
    exp_t x;
    launch();
    total++;
    if ({done, timed_out, cycle_count} !== {1'b0, 1'b0, 8'd0}) begin
      bad++;
      $display("FAIL restart_from_done got done=%0b to=%0b count=%0d want 0 0 0", done, timed_out, cycle_count);
    end
    sb.push_back('{52, 1'b0, 1'b1, 1'b1, 8'd50});
    run_until_idle(1000, 0, 1000, 100, end_e, req_e, busy_e);
    x = sb.pop_front();
    total++;
    if (end_e !== x.end_edge) begin bad++; $display("FAIL timeout_end_edge got=%0d want=%0d", end_e, x.end_edge); end
    total++;
    if ({done, timed_out, req} !== {x.done, x.timed_out, 1'b0}) begin bad++; $display("FAIL timeout_flags got=%b want=%b", {done, timed_out, req}, {x.done, x.timed_out, 1'b0}); end
    repeat (3) step();
    total++;
    if ({timed_out, cycle_count} !== {1'b1, x.count}) begin
      bad++;
      $display("FAIL timeout_count got to=%0b count=%0d want 1 %0d", timed_out, cycle_count, x.count);
    end
    $display("timeout: end=%0d to=%0b count=%0d", end_e, timed_out, cycle_count);
  endtask

  task automatic test_tie();
    int end_e, req_e, busy_e;
    exp_t x;
    launch();
    total++;
    if (timed_out !== 1'b0) begin bad++; $display("FAIL restart_from_timeout got=%0b want=0", timed_out); end
    sb.push_back('{52, 1'b1, 1'b0, 1'b0, 8'd0});
    run_until_idle(1000, 0, 50, 100, end_e, req_e, busy_e);
    x = sb.pop_front();
    total++;
    if (end_e !== x.end_edge) begin bad++; $display("FAIL tie_end_edge got=%0d want=%0d", end_e, x.end_edge); end
    total++;
    if ({done, timed_out} !== {x.done, x.timed_out}) begin bad++; $display("FAIL tie_flags got=%b want=%b", {done, timed_out}, {x.done, x.timed_out}); end
    $display("tie: end=%0d done=%0b to=%0b", end_e, done, timed_out);
  endtask

  task automatic test_control();
    exp_t x;
    launch();
    total++;
    if ({done, cycle_count} !== {1'b0, 8'd0}) begin
      bad++;
      $display("FAIL ctrl_restart got done=%0b count=%0d want 0 0", done, cycle_count);
    end
    sb.push_back('{8, 1'b0, 1'b0, 1'b1, 8'd7});
    for (int e = 2; e <= 8; e++) begin
      start = (e == 6);
      abort = (e == 8);
      step();
      if (e == 7) begin
        total++;
        if ({busy, cycle_count} !== {1'b1, 8'd6}) begin
          bad++;
          $display("FAIL ctrl_start_ignored got busy=%0b count=%0d want 1 6", busy, cycle_count);
        end
      end
    end
    start = 1'b0;
    abort = 1'b0;
    x = sb.pop_front();
    total++;
    if ({busy, req, done, timed_out, cycle_count} !== {4'b0000, x.count}) begin
      bad++;
      $display("FAIL ctrl_abort got=%b want=%b", {busy, req, done, timed_out, cycle_count}, {4'b0000, x.count});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    total++;
    if ({busy, cycle_count} !== {1'b0, 8'd7}) begin
      bad++;
      $display("FAIL ctrl_abort_idle got busy=%0b count=%0d want 0 7", busy, cycle_count);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    total++;
    if ({busy, req, cycle_count} !== {2'b11, 8'd0}) begin
      bad++;
      $display("FAIL ctrl_start_abort got busy=%0b req=%0b count=%0d want 1 1 0", busy, req, cycle_count);
    end
    step();
    abort = 1'b0;
    total++;
    if ({busy, req, cycle_count} !== {2'b00, 8'd1}) begin
      bad++;
      $display("FAIL ctrl_abort_launch got busy=%0b req=%0b count=%0d want 0 0 1", busy, req, cycle_count);
    end
    $display("control: busy=%0b count=%0d", busy, cycle_count);
  endtask

  task automatic test_async_reset();
    launch();
    repeat (9) step();
    total++;
    if ({busy, cycle_count} !== {1'b1, 8'd9}) begin
      bad++;
      $display("FAIL areset_pre got busy=%0b count=%0d want 1 9", busy, cycle_count);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({req, busy, done, timed_out, cycle_count} !== 12'd0) begin
      bad++;
      $display("FAIL areset_immediate got=%b want=0", {req, busy, done, timed_out, cycle_count});
    end
    repeat (2) @(posedge clock);
    #3 reset = 1'b0;
    repeat (4) step();
    total++;
    if ({req, busy, cycle_count} !== {2'b00, 8'd0}) begin
      bad++;
      $display("FAIL areset_idle got req=%0b busy=%0b count=%0d want 0 0 0", req, busy, cycle_count);
    end
    $display("async_reset: busy=%0b count=%0d", busy, cycle_count);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ack_glitch();
    test_timeout();
    test_tie();
    test_control();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
